// File: rtl/m2s_request_issuer_if.sv
`default_nettype none
// ============================================================================
// Module      : m2s_request_issuer_if
// Description : Bundles the client command channel, the request/response
//               channels toward the Multi2Sim memory interface and the
//               client response channel of m2s_request_issuer.
//               master modport : the issuer (drives cmd_ready, access_en,
//                                request_out, ident_out, rsp_*)
//               slave modport  : client + memory side (drives cmd_*, resp_*)
// Parameters  : ID_W - width of the locally used transaction ID (rsp_id)
// Revision    : 1.0 - initial release
// ============================================================================
interface m2s_request_issuer_if #(
  parameter int ID_W = 4
);
  // client command channel
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_rw;
  logic [30:0]     cmd_addr;
  logic [31:0]     cmd_wdata;
  // request toward the memory interface
  logic            access_en;
  logic [63:0]     request_out;
  logic [9:0]      ident_out;
  // response from the memory interface
  logic            resp_valid;
  logic [31:0]     resp_data;
  logic [9:0]      resp_id;
  // response toward the client
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic [ID_W-1:0] rsp_id;
  logic            rsp_rw;
  logic [30:0]     rsp_addr;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  resp_valid, resp_data, resp_id,
    output cmd_ready, access_en, request_out, ident_out,
    output rsp_valid, rsp_data, rsp_id, rsp_rw, rsp_addr
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output resp_valid, resp_data, resp_id,
    input  cmd_ready, access_en, request_out, ident_out,
    input  rsp_valid, rsp_data, rsp_id, rsp_rw, rsp_addr
  );
endinterface
`default_nettype wire

// File: rtl/m2s_request_issuer.sv
`default_nettype none
// ============================================================================
// Module      : m2s_request_issuer
// Description : Initiator side of the Multi2Sim VPI memory interface.
//               Accepts client commands, allocates the lowest free
//               transaction ID, emits a one-cycle access_en strobe with the
//               packed request {rw, addr[30:0], data[31:0]}, tracks the
//               outstanding IDs and matches returned {data, id} responses
//               back to the originating command.
// Ports       : clk, reset (asynchronous, active-high)
//               bus          - m2s_request_issuer_if.master (cmd/req/resp/rsp)
//               outstanding  - number of busy table entries (0..2**ID_W)
//               err_unexp    - pulse: response ID out of range or not busy
//               timeout_err  - pulse: an entry aged out (0 without macro)
//               timeout_id   - ID that aged out
// Parameters  : ID_W (table depth 2**ID_W), TIMEOUT (age limit in cycles)
// Config      : define M2S_REQ_TIMEOUT_EN to enable per-entry age counters
// Revision    : 1.0 - initial release
// ============================================================================
module m2s_request_issuer #(
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 1024
) (
  input  wire                   clk,
  input  wire                   reset,
  m2s_request_issuer_if.master  bus,
  output logic [ID_W:0]         outstanding,
  output logic                  err_unexp,
  output logic                  timeout_err,
  output logic [ID_W-1:0]       timeout_id
);

  localparam int              c_DEPTH     = 1 << ID_W;
  localparam logic [ID_W:0]   c_DEPTH_CNT = (ID_W + 1)'(c_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_DEPTH-1:0]  r_busy;
  logic [ID_W:0]       r_outstanding;
  logic                r_cmd_ready;
  logic                r_access_en;
  logic [63:0]         r_request;
  logic [9:0]          r_ident;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_data;
  logic [ID_W-1:0]     r_rsp_id;
  logic                r_rsp_rw;
  logic [30:0]         r_rsp_addr;
  logic                r_err_unexp;
  logic                r_timeout_err;
  logic [ID_W-1:0]     r_timeout_id;

  // command table, no reset needed: an entry is only read while busy
  logic                r_rw_tab   [c_DEPTH];
  logic [30:0]         r_addr_tab [c_DEPTH];

  logic                w_accept;
  logic                w_resp_in_range;
  logic [ID_W-1:0]     w_resp_idx;
  logic                w_resp_hit;
  logic [ID_W-1:0]     w_free_id;
  logic                w_to_fire;
  logic [ID_W-1:0]     w_to_id;
  logic [c_DEPTH-1:0]  w_busy_next;
  logic [ID_W:0]       w_count_next;

  assign w_accept        = bus.cmd_valid & r_cmd_ready;
  // any set bit above the local ID field means the ID cannot be ours
  assign w_resp_in_range = ((bus.resp_id >> ID_W) == 10'd0);
  assign w_resp_idx      = bus.resp_id[ID_W-1:0];
  assign w_resp_hit      = bus.resp_valid & w_resp_in_range & r_busy[w_resp_idx];

  // lowest-index free entry; cmd_ready guarantees one exists when accepting
  always_comb begin
    w_free_id = '0;
    for (int i = c_DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_id = ID_W'(i);
      end
    end
  end

`ifdef M2S_REQ_TIMEOUT_EN
  localparam int                 c_AGE_W    = $clog2(TIMEOUT) + 1;
  localparam logic [c_AGE_W-1:0] c_AGE_LAST = c_AGE_W'(TIMEOUT - 1);

  logic [c_AGE_W-1:0] r_age [c_DEPTH];
  logic [c_DEPTH-1:0] w_expired;

  // An entry sitting at TIMEOUT-1 would reach TIMEOUT on this edge, so it
  // expires now. A response to the same entry wins and masks the expiry.
  // Unserved expiries keep their saturated age and fire on later cycles.
  always_comb begin
    w_expired = '0;
    w_to_fire = 1'b0;
    w_to_id   = '0;
    for (int i = c_DEPTH - 1; i >= 0; i--) begin
      w_expired[i] = r_busy[i] && (r_age[i] == c_AGE_LAST) &&
                     !(w_resp_hit && (w_resp_idx == ID_W'(i)));
      if (w_expired[i]) begin
        w_to_fire = 1'b1;
        w_to_id   = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_DEPTH; i++) begin
        if (w_accept && (w_free_id == ID_W'(i))) begin
          r_age[i] <= '0;
        end else if (r_busy[i] && (r_age[i] != c_AGE_LAST)) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end
`else
  assign w_to_fire = 1'b0;
  assign w_to_id   = '0;
`endif

  // Allocation picks a non-busy entry while response/timeout clear busy ones,
  // so the set and the clears never target the same bit.
  always_comb begin
    w_busy_next = r_busy;
    if (w_accept) begin
      w_busy_next[w_free_id] = 1'b1;
    end
    if (w_resp_hit) begin
      w_busy_next[w_resp_idx] = 1'b0;
    end
    if (w_to_fire) begin
      w_busy_next[w_to_id] = 1'b0;
    end
  end

  assign w_count_next = r_outstanding
                      + (ID_W + 1)'(w_accept)
                      - (ID_W + 1)'(w_resp_hit)
                      - (ID_W + 1)'(w_to_fire);

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rw_tab[w_free_id]   <= bus.cmd_rw;
      r_addr_tab[w_free_id] <= bus.cmd_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_busy        <= '0;
      r_outstanding <= '0;
      r_cmd_ready   <= 1'b0;
      r_access_en   <= 1'b0;
      r_request     <= '0;
      r_ident       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_id      <= '0;
      r_rsp_rw      <= 1'b0;
      r_rsp_addr    <= '0;
      r_err_unexp   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_timeout_id  <= '0;
    end else begin
      r_busy        <= w_busy_next;
      r_outstanding <= w_count_next;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_ISSUE;
            r_cmd_ready <= 1'b0;
            r_access_en <= 1'b1;
            r_request   <= {bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata};
            r_ident     <= 10'(w_free_id);
          end else begin
            r_cmd_ready <= (w_count_next < c_DEPTH_CNT);
          end
        end
        ST_ISSUE: begin
          r_state     <= ST_IDLE;
          r_access_en <= 1'b0;
          r_cmd_ready <= (w_count_next < c_DEPTH_CNT);
        end
        default: begin
          r_state     <= ST_IDLE;
          r_access_en <= 1'b0;
          r_cmd_ready <= 1'b0;
        end
      endcase

      r_rsp_valid <= w_resp_hit;
      if (w_resp_hit) begin
        r_rsp_data <= bus.resp_data;
        r_rsp_id   <= w_resp_idx;
        r_rsp_rw   <= r_rw_tab[w_resp_idx];
        r_rsp_addr <= r_addr_tab[w_resp_idx];
      end
      r_err_unexp <= bus.resp_valid & ~w_resp_hit;

      r_timeout_err <= w_to_fire;
      if (w_to_fire) begin
        r_timeout_id <= w_to_id;
      end
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.access_en   = r_access_en;
  assign bus.request_out = r_request;
  assign bus.ident_out   = r_ident;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_rw      = r_rsp_rw;
  assign bus.rsp_addr    = r_rsp_addr;
  assign outstanding     = r_outstanding;
  assign err_unexp       = r_err_unexp;
  assign timeout_err     = r_timeout_err;
  assign timeout_id      = r_timeout_id;

endmodule
`default_nettype wire

// File: tb/tb_m2s_request_issuer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_m2s_request_issuer
// Description : Self-checking bench for m2s_request_issuer (default build).
//               Expected requests and client responses are queued when the
//               stimulus is driven and compared when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m2s_request_issuer;

  localparam int ID_W  = 4;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [ID_W:0]   outstanding;
  logic            err_unexp;
  logic            timeout_err;
  logic [ID_W-1:0] timeout_id;

  m2s_request_issuer_if #(.ID_W(ID_W)) bus ();

  m2s_request_issuer #(.ID_W(ID_W), .TIMEOUT(1024)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .outstanding (outstanding),
    .err_unexp   (err_unexp),
    .timeout_err (timeout_err),
    .timeout_id  (timeout_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] req;
    logic [9:0]  ident;
  } iss_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic        rw;
    logic [30:0] addr;
  } rsp_t;

  typedef struct {
    logic        rw;
    logic [30:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [63:0] exp_req;
  } vec_t;

  iss_t        iss_q[$];
  rsp_t        rsp_q[$];
  int          exp_err = 0;
  int          checks = 0;
  int          failures = 0;

  logic        m_busy [DEPTH];
  logic        m_rw   [DEPTH];
  logic [30:0] m_addr [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_free();
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_busy[i]) return i;
    end
    return -1;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i]) n++;
    end
    return n;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 1'b0;
      m_rw[i]   = 1'b0;
      m_addr[i] = '0;
    end
  endtask

  task automatic check_out(input string name);
    check(name, 64'(outstanding), 64'(m_count()));
  endtask

  // Waits (bounded) for cmd_ready, presents one command for one cycle.
  task automatic send_cmd(input logic rw, input logic [30:0] addr,
                          input logic [31:0] data, input logic [63:0] exp_req);
    int n = 0;
    int id;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL cmd_ready_wait: got %b expected 1", bus.cmd_ready);
      return;
    end
    id = m_free();
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    iss_q.push_back('{req: exp_req, ident: 10'(id)});
    m_busy[id] = 1'b1;
    m_rw[id]   = rw;
    m_addr[id] = addr;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_resp(input int id, input logic [31:0] data);
    bus.resp_valid = 1'b1;
    bus.resp_id    = 10'(id);
    bus.resp_data  = data;
    if (id < DEPTH && m_busy[id]) begin
      rsp_q.push_back('{data: data, id: 4'(id), rw: m_rw[id], addr: m_addr[id]});
      m_busy[id] = 1'b0;
    end else begin
      exp_err++;
    end
    @(negedge clk);
    bus.resp_valid = 1'b0;
  endtask

  // Scoreboard side: compare whatever the DUT presents against the queues.
  always @(negedge clk) begin
    iss_t ie;
    rsp_t re;
    if (bus.access_en === 1'b1) begin
      if (iss_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL access_en_unexpected: got 1 expected 0");
      end else begin
        ie = iss_q.pop_front();
        check("request_out", bus.request_out, ie.req);
        check("ident_out", 64'(bus.ident_out), 64'(ie.ident));
      end
    end
    if (bus.rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_valid_unexpected: got 1 expected 0");
      end else begin
        re = rsp_q.pop_front();
        check("rsp_data", 64'(bus.rsp_data), 64'(re.data));
        check("rsp_id", 64'(bus.rsp_id), 64'(re.id));
        check("rsp_rw", 64'(bus.rsp_rw), 64'(re.rw));
        check("rsp_addr", 64'(bus.rsp_addr), 64'(re.addr));
      end
    end
    if (err_unexp === 1'b1) begin
      checks++;
      if (exp_err == 0) begin
        failures++;
        $display("FAIL err_unexp_unexpected: got 1 expected 0");
      end else begin
        exp_err--;
      end
    end
    if (timeout_err !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL timeout_err: got %b expected 0", timeout_err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs [5];

  initial begin
    int nid;
    vecs[0] = '{1'b0, 31'h0000_0040, 32'h0000_0000, 32'h1111_2222, 64'h0000_0040_0000_0000};
    vecs[1] = '{1'b1, 31'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 64'h8000_1234_DEAD_BEEF};
    vecs[2] = '{1'b0, 31'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 64'h7FFF_FFFF_FFFF_FFFF};
    vecs[3] = '{1'b1, 31'h0000_0000, 32'h0000_0000, 32'h8000_0000, 64'h8000_0000_0000_0000};
    vecs[4] = '{1'b1, 31'h2AAA_AAAA, 32'h5555_5555, 32'hA5A5_5A5A, 64'hAAAA_AAAA_5555_5555};

    m_clear();
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_rw     = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_wdata  = '0;
    bus.resp_valid = 1'b0;
    bus.resp_id    = '0;
    bus.resp_data  = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_access_en", 64'(bus.access_en), 64'd0);
    check("rst_request_out", bus.request_out, 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_err_unexp", 64'(err_unexp), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // table-driven single transactions, each answered before the next
    for (int v = 0; v < 5; v++) begin
      send_cmd(vecs[v].rw, vecs[v].addr, vecs[v].wdata, vecs[v].exp_req);
      @(negedge clk);
      check_out("vec_outstanding_busy");
      send_resp(0, vecs[v].rdata);
      check_out("vec_outstanding_free");
    end

    // fill every entry with no responses
    for (int i = 0; i < DEPTH; i++) begin
      send_cmd(1'b0, 31'(32'h100 + 32'(i)), 32'(i), {1'b0, 31'(32'h100 + 32'(i)), 32'(i)});
    end
    repeat (2) @(negedge clk);
    check("full_outstanding", 64'(outstanding), 64'd16);
    check("full_cmd_ready", 64'(bus.cmd_ready), 64'd0);

    // free ID 5, it must be the next one allocated
    send_resp(5, 32'hCAFE_0005);
    check_out("free5_outstanding");
    send_cmd(1'b1, 31'h0000_0555, 32'h0BAD_F00D, {1'b1, 31'h0000_0555, 32'h0BAD_F00D});
    @(negedge clk);
    check_out("realloc5_outstanding");

    // unknown responses: out-of-range ID, then an entry that is not busy
    send_resp(20, 32'h0000_0020);
    send_resp(3, 32'h0000_0003);
    send_resp(3, 32'h0000_0033);
    @(negedge clk);
    check_out("unexp_outstanding");

    // simultaneous accept and response freeing ID 0
    begin
      int n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("both_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      nid = m_free();
      check("both_new_id_not0", 64'(nid != 0), 64'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_rw    = 1'b0;
      bus.cmd_addr  = 31'h0000_0ABC;
      bus.cmd_wdata = 32'h1234_5678;
      iss_q.push_back('{req: {1'b0, 31'h0000_0ABC, 32'h1234_5678}, ident: 10'(nid)});
      bus.resp_valid = 1'b1;
      bus.resp_id    = 10'd0;
      bus.resp_data  = 32'h0000_AAAA;
      rsp_q.push_back('{data: 32'h0000_AAAA, id: 4'd0, rw: m_rw[0], addr: m_addr[0]});
      m_busy[0]     = 1'b0;
      m_busy[nid]   = 1'b1;
      m_rw[nid]     = 1'b0;
      m_addr[nid]   = 31'h0000_0ABC;
      @(negedge clk);
      bus.cmd_valid  = 1'b0;
      bus.resp_valid = 1'b0;
      check("both_outstanding", 64'(outstanding), 64'd15);
    end

    // drain everything
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i]) send_resp(i, 32'h5000_0000 + 32'(i));
    end
    check_out("drain_outstanding");

    // reset in the middle of an ISSUE cycle with 4 outstanding
    for (int i = 0; i < 3; i++) begin
      send_cmd(1'b1, 31'(32'h200 + 32'(i)), 32'hF0 + 32'(i), {1'b1, 31'(32'h200 + 32'(i)), 32'hF0 + 32'(i)});
    end
    begin
      int n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_rw    = 1'b0;
      bus.cmd_addr  = 31'h0000_0300;
      bus.cmd_wdata = 32'h0;
      @(posedge clk);
      #2;
      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      check("rstmid_access_en", 64'(bus.access_en), 64'd0);
      check("rstmid_outstanding", 64'(outstanding), 64'd0);
      check("rstmid_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      m_clear();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
    end
    send_cmd(1'b0, 31'h0000_0400, 32'h0, 64'h0000_0400_0000_0000);
    @(negedge clk);
    check_out("postrst_outstanding");
    send_resp(0, 32'h7777_7777);
    check_out("postrst_drained");

    // everything expected must have been seen
    repeat (3) @(negedge clk);
    check("iss_q_empty", 64'(iss_q.size()), 64'd0);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    check("err_all_seen", 64'(exp_err), 64'd0);
    check("timeout_id_zero", 64'(timeout_id), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
